// File: rtl/i2c_slave.sv
// I2C register-access slave: 7-bit address, 8-bit sub-address pointer with auto-increment,
// byte writes to and reads from a user register file through a simple strobe interface.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk_50,
  input  logic       reset,
  inout  wire        SDA,
  input  logic       SCL,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  input  logic [7:0] rd_data,
  output logic       rd_ack,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    SUBADDR,
    WDATA,
    RDATA,
    ACK,
    RACK,
    WAIT
  } state_t;

  logic              sda_s1_q, sda_s2_q, sda_h_q;
  logic              scl_s1_q, scl_s2_q, scl_h_q;
  logic              scl_rise, scl_fall, start_det, stop_det;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_ack_q, rd_ack_d;
  logic              busy_q, busy_d;
  logic              sda_oe_q, sda_oe_d;
  logic [BYTE_W-1:0] rx_byte;

  // Bus synchronisers; reset to the idle (high) level so no event fires on reset release.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
    end else begin
      sda_s1_q <= SDA;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
      scl_s1_q <= SCL;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
  assign stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
  assign rx_byte   = {shift_q[BYTE_W-2:0], sda_s2_q};

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_ack_q   <= rd_ack_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  // Next-state logic; bus START/STOP outrank any SCL edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_addr_d = wr_en_q ? reg_addr_q + 8'd1 : reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_ack_d   = 1'b0;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, SUBADDR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              state_d   = ACK;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  busy_d = 1'b1;
                  ret_d  = rx_byte[0] ? RDATA : SUBADDR;
                end else begin
                  state_d = WAIT;
                  busy_d  = 1'b0;
                end
              end else if (state_q == SUBADDR) begin
                reg_addr_d = rx_byte;
                ret_d      = WDATA;
              end else begin
                wr_data_d = rx_byte;
                wr_en_d   = 1'b1;
                ret_d     = WDATA;
              end
            end
          end
        end
        // First SCL fall starts the ACK drive, the second one ends the ACK bit.
        ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (ret_q == RDATA) begin
              shift_d    = rd_data;
              rd_ack_d   = 1'b1;
              reg_addr_d = reg_addr_q + 8'd1;
              sda_oe_d   = ~rd_data[7];
              bit_cnt_d  = '0;
              state_d    = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ret_q;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == CNT_W'(8)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RACK;
            end else begin
              sda_oe_d = ~shift_q[3'(CNT_W'(7) - bit_cnt_q)];
            end
          end
        end
        RACK: begin
          if (scl_rise && sda_s2_q) begin
            state_d = WAIT;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            shift_d    = rd_data;
            rd_ack_d   = 1'b1;
            reg_addr_d = reg_addr_q + 8'd1;
            sda_oe_d   = ~rd_data[7];
            bit_cnt_d  = '0;
            state_d    = RDATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign rd_ack   = rd_ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master tasks, a user register file, and a memory model
// holding the expected register contents and write sequence.
module tb_i2c_slave;

  localparam int unsigned Q = 8;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       SCL;
  logic       m_low;
  wire        SDA;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, rd_ack, busy;

  always #10 clk_50 = ~clk_50;

  assign SDA = m_low ? 1'b0 : 1'bz;
  pullup (SDA);

  logic [7:0] mem       [256];
  logic [7:0] model_mem [256];
  assign rd_data = mem[reg_addr];

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .SDA      (SDA),
    .SCL      (SCL),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_data  (rd_data),
    .rd_ack   (rd_ack),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wr_q [$];
  int rd_cnt        = 0;
  int slave_low_cnt = 0;
  int busy_cnt      = 0;

  always @(posedge clk_50) begin
    if (wr_en) wr_q.push_back({reg_addr, wr_data});
    if (rd_ack) rd_cnt <= rd_cnt + 1;
    if (SDA === 1'b0 && !m_low) slave_low_cnt <= slave_low_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic bus_start();
    m_low = 1'b0; tick(Q);
    SCL = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    SCL = 1'b0;   tick(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; tick(Q);
    SCL = 1'b1;   tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; tick(Q);
    SCL = 1'b1; tick(2 * Q);
    SCL = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; tick(Q);
    SCL = 1'b1;   tick(Q);
    b = SDA;      tick(Q);
    SCL = 1'b0;   tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(nack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // User side: apply the captured write strobes to the register file.
  task automatic commit_writes();
    while (wr_q.size() > 0) begin
      logic [15:0] e;
      e = wr_q.pop_front();
      mem[e[15:8]] = e[7:0];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; SCL = 1'b1; m_low = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'(i) ^ 8'hFF;
      model_mem[i] = 8'(i) ^ 8'hFF;
    end
    tick(5);
    n_tests++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_reg_addr got %h exp 00", reg_addr); end
    n_tests++; if (wr_data !== 8'h00)  begin n_fail++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
    n_tests++; if (wr_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    n_tests++; if (rd_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_ack got %b exp 0", rd_ack); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (SDA !== 1'b1)       begin n_fail++; $display("FAIL reset_sda got %b exp 1", SDA); end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_write_basic();
    logic [7:0]  bytes [4];
    logic [15:0] exp_w [2];
    logic        nack;
    bytes = '{8'h84, 8'h10, 8'hA5, 8'h5A};
    exp_w = '{16'h10A5, 16'h115A};
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], nack);
      n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL wr_basic_ack%0d got %b exp 0", i, nack); end
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_basic_busy got %b exp 1", busy); end
    bus_stop(); tick(4);
    n_tests++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL wr_basic_count got %0d exp 2", wr_q.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [15:0] got;
      got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
      n_tests++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL wr_basic_strobe%0d got %h exp %h", i, got, exp_w[i]); end
    end
    n_tests++; if (reg_addr !== 8'h12) begin n_fail++; $display("FAIL wr_basic_reg_addr got %h exp 12", reg_addr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_basic_busy_end got %b exp 0", busy); end
    model_mem[8'h10] = 8'hA5; model_mem[8'h11] = 8'h5A;
    commit_writes();
  endtask

  task automatic test_read_rstart();
    logic       n0, n1, n2;
    logic [7:0] d0, d1;
    int         r0;
    r0 = rd_cnt;
    bus_start(); send_byte(8'h84, n0); send_byte(8'h20, n1);
    bus_start(); send_byte(8'h85, n2);
    recv_byte(1'b0, d0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_mid got %b exp 1", busy); end
    recv_byte(1'b1, d1);
    bus_stop(); tick(4);
    n_tests++; if ({n0, n1, n2} !== 3'b000) begin n_fail++; $display("FAIL rd_acks got %b exp 000", {n0, n1, n2}); end
    n_tests++; if (d0 !== 8'hDF) begin n_fail++; $display("FAIL rd_byte0 got %h exp DF", d0); end
    n_tests++; if (d1 !== 8'hDE) begin n_fail++; $display("FAIL rd_byte1 got %h exp DE", d1); end
    n_tests++; if (rd_cnt - r0 != 2) begin n_fail++; $display("FAIL rd_ack_count got %0d exp 2", rd_cnt - r0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end got %b exp 0", busy); end
    n_tests++; if (reg_addr !== 8'h22) begin n_fail++; $display("FAIL rd_reg_addr got %h exp 22", reg_addr); end
  endtask

  task automatic test_no_match();
    logic n0, n1;
    int   s0, b0, w0;
    s0 = slave_low_cnt; b0 = busy_cnt; w0 = wr_q.size();
    bus_start(); send_byte(8'h90, n0); send_byte(8'h10, n1);
    bus_stop(); tick(4);
    n_tests++; if (n0 !== 1'b1) begin n_fail++; $display("FAIL nomatch_addr_ack got %b exp 1", n0); end
    n_tests++; if (n1 !== 1'b1) begin n_fail++; $display("FAIL nomatch_data_ack got %b exp 1", n1); end
    n_tests++; if (slave_low_cnt != s0) begin n_fail++; $display("FAIL nomatch_sda_driven got %0d exp %0d", slave_low_cnt, s0); end
    n_tests++; if (busy_cnt != b0) begin n_fail++; $display("FAIL nomatch_busy got %0d exp %0d", busy_cnt, b0); end
    n_tests++; if (wr_q.size() != w0) begin n_fail++; $display("FAIL nomatch_wr_en got %0d exp %0d", wr_q.size(), w0); end
  endtask

  task automatic test_wrap();
    logic [7:0] x, y;
    logic       n0, n1, n2, n3;
    logic [15:0] g0, g1;
    x = 8'($urandom); y = 8'($urandom);
    bus_start(); send_byte(8'h84, n0); send_byte(8'hFF, n1); send_byte(x, n2); send_byte(y, n3);
    bus_stop(); tick(4);
    n_tests++; if ({n0, n1, n2, n3} !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks got %b exp 0000", {n0, n1, n2, n3}); end
    n_tests++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL wrap_count got %0d exp 2", wr_q.size()); end
    g0 = (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx;
    g1 = (wr_q.size() > 1) ? wr_q[1] : 16'hxxxx;
    n_tests++; if (g0 !== {8'hFF, x}) begin n_fail++; $display("FAIL wrap_strobe0 got %h exp %h", g0, {8'hFF, x}); end
    n_tests++; if (g1 !== {8'h00, y}) begin n_fail++; $display("FAIL wrap_strobe1 got %h exp %h", g1, {8'h00, y}); end
    n_tests++; if (reg_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_reg_addr got %h exp 01", reg_addr); end
    model_mem[8'hFF] = x; model_mem[8'h00] = y;
    commit_writes();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] s, s2, x, y;
    logic       n, n0, n1, n2, n3, b;
    logic [15:0] g0, g1;
    s = 8'($urandom);
    bus_start(); send_byte(8'h84, n); send_byte(s, n); send_byte(8'h00, n);
    bus_stop(); tick(4);
    model_mem[s] = 8'h00;
    commit_writes();
    bus_start(); send_byte(8'h84, n); send_byte(s, n);
    bus_start(); send_byte(8'h85, n);
    for (int i = 0; i < 3; i++) recv_bit(b);
    m_low = 1'b0; tick(Q);
    SCL = 1'b1;   tick(Q);
    n_tests++; if (SDA !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bit4_driven got %b exp 0", SDA); end
    reset = 1'b1; tick(1);
    n_tests++; if (SDA !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sda got %b exp 1", SDA); end
    n_tests++; if ({reg_addr, wr_data} !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_regs got %h exp 0000", {reg_addr, wr_data}); end
    n_tests++; if ({wr_en, rd_ack, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags got %b exp 000", {wr_en, rd_ack, busy}); end
    tick(3); SCL = 1'b0; tick(Q);
    reset = 1'b0; tick(Q);
    send_byte(8'h84, n);
    n_tests++; if (n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ignore_no_start got %b exp 1", n); end
    bus_stop(); tick(4);
    s2 = 8'($urandom_range(0, 253)); x = 8'($urandom); y = 8'($urandom);
    bus_start(); send_byte(8'h84, n0); send_byte(s2, n1); send_byte(x, n2); send_byte(y, n3);
    bus_stop(); tick(4);
    n_tests++; if ({n0, n1, n2, n3} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_wr_acks got %b exp 0000", {n0, n1, n2, n3}); end
    g0 = (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx;
    g1 = (wr_q.size() > 1) ? wr_q[1] : 16'hxxxx;
    n_tests++; if (g0 !== {s2, x}) begin n_fail++; $display("FAIL rst_mid_strobe0 got %h exp %h", g0, {s2, x}); end
    n_tests++; if (g1 !== {s2 + 8'd1, y}) begin n_fail++; $display("FAIL rst_mid_strobe1 got %h exp %h", g1, {s2 + 8'd1, y}); end
    n_tests++; if (reg_addr !== s2 + 8'd2) begin n_fail++; $display("FAIL rst_mid_reg_addr got %h exp %h", reg_addr, s2 + 8'd2); end
    model_mem[s2] = x; model_mem[s2 + 8'd1] = y;
    commit_writes();
  endtask

  task automatic test_stop_mid_byte();
    logic [7:0] s;
    logic       n;
    int         w0;
    s = 8'($urandom);
    w0 = wr_q.size();
    bus_start(); send_byte(8'h84, n); send_byte(s, n);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop(); tick(4);
    n_tests++; if (wr_q.size() != w0) begin n_fail++; $display("FAIL stopmid_wr_en got %0d exp %0d", wr_q.size(), w0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stopmid_busy got %b exp 0", busy); end
    n_tests++; if (reg_addr !== s) begin n_fail++; $display("FAIL stopmid_reg_addr got %h exp %h", reg_addr, s); end
    SCL = 1'b0; tick(Q);
    send_byte(8'h84, n);
    n_tests++; if (n !== 1'b1) begin n_fail++; $display("FAIL stopmid_idle_ack got %b exp 1", n); end
    bus_stop(); tick(4);
  endtask

  // Random write transaction followed by a read-back transaction of the same window.
  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      logic [7:0]  s, d, exp_d;
      logic [7:0]  data [4];
      logic [15:0] got;
      logic        n, acks;
      int          len;
      s = 8'($urandom); len = int'($urandom_range(1, 4)); acks = 1'b0;
      bus_start(); send_byte(8'h84, n); acks |= n; send_byte(s, n); acks |= n;
      for (int i = 0; i < len; i++) begin
        data[i] = 8'($urandom);
        send_byte(data[i], n); acks |= n;
      end
      bus_stop(); tick(4);
      n_tests++; if (acks !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_wr_acks got nack", t); end
      n_tests++; if (wr_q.size() != len) begin n_fail++; $display("FAIL b2b%0d_count got %0d exp %0d", t, wr_q.size(), len); end
      for (int i = 0; i < len; i++) begin
        got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
        n_tests++; if (got !== {s + 8'(i), data[i]}) begin n_fail++; $display("FAIL b2b%0d_strobe%0d got %h exp %h", t, i, got, {s + 8'(i), data[i]}); end
        model_mem[s + 8'(i)] = data[i];
      end
      commit_writes();
      bus_start(); send_byte(8'h84, n); acks = n; send_byte(s, n); acks |= n;
      bus_start(); send_byte(8'h85, n); acks |= n;
      for (int i = 0; i < len; i++) begin
        recv_byte(i == len - 1, d);
        exp_d = model_mem[s + 8'(i)];
        n_tests++; if (d !== exp_d) begin n_fail++; $display("FAIL b2b%0d_rd%0d got %h exp %h", t, i, d, exp_d); end
      end
      bus_stop(); tick(4);
      n_tests++; if (acks !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_rd_acks got nack", t); end
      n_tests++; if (reg_addr !== s + 8'(len)) begin n_fail++; $display("FAIL b2b%0d_reg_addr got %h exp %h", t, reg_addr, s + 8'(len)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_rstart();
    test_no_match();
    test_wrap();
    test_reset_mid_read();
    test_stop_mid_byte();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42, giving the 7-bit bus address this block responds to.
REQ-002 SHALL have port clk_50, input, 1 bit: system clock, 50 MHz; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port SDA, inout, 1 bit: open-drain bus data; the block drives only 0 or Z.
REQ-005 SHALL have port SCL, input, 1 bit: bus clock, driven by the master; no clock stretching.
REQ-006 SHALL have port reg_addr, output, 8 bits: register pointer (sub-address).
REQ-007 SHALL have port wr_data, output, 8 bits: last byte received from the master.
REQ-008 SHALL have port wr_en, output, 1 bit: one-cycle pulse; wr_data is to be written at reg_addr.
REQ-009 SHALL have port rd_data, input, 8 bits: register contents at reg_addr, supplied by the user combinationally.
REQ-010 SHALL have port rd_ack, output, 1 bit: one-cycle pulse when rd_data is latched for transmit.
REQ-011 SHALL have port busy, output, 1 bit: high from an addressed START until STOP, NACK or a non-matching address.

Function
REQ-012 SHALL pass SDA and SCL through 2-FF synchronisers plus one history register; bus events are detected 3 clk_50 cycles after the pin change.
REQ-013 SHALL detect START as SDA falling while SCL is high, STOP as SDA rising while SCL is high, and SCL rise/fall as synchronised edges.
REQ-014 SHALL sample SDA on SCL rise, MSB first, and change its own SDA drive only on a detected SCL fall.
REQ-015 SHALL use these states: IDLE, ADDR, SUBADDR, WDATA, RDATA, ACK, RACK, WAIT.
REQ-016 SHALL, on START in any state including mid-byte (a repeated start), go to ADDR, clear the bit counter and release SDA; reg_addr is kept.
REQ-017 SHALL, on STOP in any state, go to IDLE, release SDA and drop busy.
REQ-018 SHALL, in ADDR after 8 bits: if bits[7:1] equal SLAVE_ADDR, ACK (drive SDA low for the 9th SCL period) and set busy; otherwise go to WAIT with SDA released.
REQ-019 SHALL, when the R/W bit is 0, follow the ACK with SUBADDR; the next byte loads reg_addr and is ACKed, then WDATA follows.
REQ-020 SHALL, for each 8-bit byte in WDATA, set wr_data, pulse wr_en for 1 cycle on the 8th SCL rise, ACK the byte, and increment reg_addr one cycle after wr_en.
REQ-021 SHALL, when the R/W bit is 1, after the address ACK: on the SCL fall ending ACK, latch rd_data into the shift register, pulse rd_ack, increment reg_addr, and drive bit 7.
REQ-022 SHALL, in RDATA, shift out 8 bits, then release SDA and sample the master's acknowledge in RACK.
REQ-023 SHALL, in RACK, on SDA=0 (ACK) load the next byte as in REQ-021; on SDA=1 (NACK) go to WAIT with SDA released.
REQ-024 SHALL have reg_addr increment modulo 256, so 8'hFF wraps to 8'h00.
REQ-025 SHALL, in WAIT, ignore all bits until START or STOP.
REQ-026 SHALL give STOP or START priority over an SCL edge detected in the same cycle.
REQ-027 SHALL treat a repeated START after SUBADDR with R/W=1 as a read starting at the loaded reg_addr.

Reset
REQ-028 SHALL, while reset is high, put the state to IDLE, set reg_addr=0, wr_data=0, wr_en=0, rd_ack=0, busy=0, SDA=Z, bit counter=0, and set the synchroniser FFs to 1.
REQ-029 SHALL, on reset asserted mid-transfer, release SDA in the next cycle, and after deassertion ignore bus traffic until the next START.

Verification
REQ-030 Bench SHALL cover this scenario: START, 0x84, 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_en pulses with (reg_addr, wr_data) = (0x10, 0xA5), then (0x11, 0x5A); final reg_addr = 0x12.
REQ-031 Bench SHALL cover this scenario: START, 0x84, 0x20, repeated START, 0x85, read 2 bytes (ACK then NACK), STOP, with rd_data = reg_addr XOR 0xFF -> SDA bytes 0xDF then 0xDE; 2 rd_ack pulses; busy drops at STOP.
REQ-032 Bench SHALL cover this scenario: START, 0x90 (address 0x48), 0x10, STOP -> no ACK (SDA stays Z throughout), no wr_en, busy stays 0.
REQ-033 Bench SHALL cover this scenario: write with sub-address 0xFF and 2 data bytes -> writes at 0xFF then 0x00; reg_addr ends at 0x01.
REQ-034 Bench SHALL cover this scenario: reset pulsed during the 4th bit of a read byte -> SDA = Z within 1 cycle; outputs at reset values; a subsequent valid write transaction completes correctly.
REQ-035 Bench SHALL cover this scenario: STOP issued mid-byte during a write -> no wr_en, state IDLE, busy = 0.
